// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - FSM state encoding (IDLE, CMP, DONE)
//   - ndig():        number of DIGIT-wide groups in a WIDTH-bit operand
//   - idx_bits():    width of the group index counter
//   - geometry_ok(): elaboration-time legality check of WIDTH/DIGIT
// ---------------------------------------------------------------------------
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-group design still needs a 1-bit index register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit geometry_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// ---------------------------------------------------------------------------
// digit_cmp
// Combinational unsigned compare of one DIGIT-bit group.
// Ports:
//   a, b    input  [DIGIT-1:0]  group slices of the two operands
//   grp_eq  output              a == b
//   grp_gt  output              a >  b
//   grp_lt  output              a <  b (neither equal nor greater)
// ---------------------------------------------------------------------------
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             grp_eq,
    output logic             grp_gt,
    output logic             grp_lt
);

    assign grp_eq = (a == b);
    assign grp_gt = (a > b);
    assign grp_lt = ~grp_eq & ~grp_gt;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
// Multi-cycle magnitude comparator: scans DIGIT bits per cycle from the
// most-significant group down and stops at the first unequal group.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request, accepted when busy=0 (IDLE or DONE)
//   a, b          WIDTH-bit operands, sampled on the accepting edge
//   signed_mode   1 = two's-complement compare, sampled with a/b
//   busy          high while scanning
//   done          one-cycle pulse, result valid
//   eq, gt, lt    result flags, A relative to B
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    import cmp_pkg::*;

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int IDXW = idx_bits(NDIG);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    if (!geometry_ok(WIDTH, DIGIT)) begin : g_bad_geometry
        $error("seq_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sign_flip;
    logic [DIGIT-1:0] a_grp;
    logic [DIGIT-1:0] b_grp;
    logic             grp_eq;
    logic             grp_gt;
    logic             grp_lt;

    // Inverting both sign bits maps two's-complement order onto unsigned
    // order, so the scan itself never needs to know the mode.
    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = signed_mode;
    end

    assign a_grp = a_q[idx*DIGIT +: DIGIT];
    assign b_grp = b_q[idx*DIGIT +: DIGIT];

    digit_cmp #(
        .DIGIT(DIGIT)
    ) u_digit_cmp (
        .a      (a_grp),
        .b      (b_grp),
        .grp_eq (grp_eq),
        .grp_gt (grp_gt),
        .grp_lt (grp_lt)
    );

    // DONE accepts a new start just like IDLE so back-to-back requests lose
    // no cycle; start is ignored in CMP so the latched operands stay intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q   <= a ^ sign_flip;
                        b_q   <= b ^ sign_flip;
                        eq    <= 1'b0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        idx   <= LAST_IDX;
                        state <= ST_CMP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    if (!grp_eq) begin
                        gt    <= grp_gt;
                        lt    <= grp_lt;
                        state <= ST_DONE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CMP);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
// Self-checking bench with three comparator instances:
//   which=0: WIDTH=16, DIGIT=4   (main configuration)
//   which=1: WIDTH=4,  DIGIT=1   (exhaustive bit-serial)
//   which=2: WIDTH=8,  DIGIT=8   (single group, always one compare cycle)
// Expected order comes from plain integer arithmetic; expected scan length
// comes from the position of the first differing group from the MSB.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s16_start, s16_sm, s16_busy, s16_done, s16_eq, s16_gt, s16_lt;
    logic [15:0] s16_a, s16_b;
    logic        s4_start, s4_sm, s4_busy, s4_done, s4_eq, s4_gt, s4_lt;
    logic [3:0]  s4_a, s4_b;
    logic        s8_start, s8_sm, s8_busy, s8_done, s8_eq, s8_gt, s8_lt;
    logic [7:0]  s8_a, s8_b;

    int tests = 0;
    int fails = 0;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .a(s16_a), .b(s16_b),
        .signed_mode(s16_sm), .busy(s16_busy), .done(s16_done),
        .eq(s16_eq), .gt(s16_gt), .lt(s16_lt)
    );

    seq_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b),
        .signed_mode(s4_sm), .busy(s4_busy), .done(s4_done),
        .eq(s4_eq), .gt(s4_gt), .lt(s4_lt)
    );

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b),
        .signed_mode(s8_sm), .busy(s8_busy), .done(s8_done),
        .eq(s8_eq), .gt(s8_gt), .lt(s8_lt)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int width_of(input int which);
        return (which == 0) ? 16 : (which == 1) ? 4 : 8;
    endfunction

    function automatic int digit_of(input int which);
        return (which == 0) ? 4 : (which == 1) ? 1 : 8;
    endfunction

    task automatic set_in(input int which, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic st);
        case (which)
            0: begin s16_a = a; s16_b = b; s16_sm = sm; s16_start = st; end
            1: begin s4_a = a[3:0]; s4_b = b[3:0]; s4_sm = sm; s4_start = st; end
            default: begin s8_a = a[7:0]; s8_b = b[7:0]; s8_sm = sm; s8_start = st; end
        endcase
    endtask

    task automatic set_start(input int which, input logic st);
        case (which)
            0: s16_start = st;
            1: s4_start = st;
            default: s8_start = st;
        endcase
    endtask

    // Packed as {busy, done, eq, gt, lt}.
    function automatic logic [4:0] outs(input int which);
        case (which)
            0: return {s16_busy, s16_done, s16_eq, s16_gt, s16_lt};
            1: return {s4_busy, s4_done, s4_eq, s4_gt, s4_lt};
            default: return {s8_busy, s8_done, s8_eq, s8_gt, s8_lt};
        endcase
    endfunction

    // 0 = eq, 1 = gt, -1 = lt, 99 = flags not one-hot.
    function automatic int decode(input logic [4:0] o);
        case (o[2:0])
            3'b100: return 0;
            3'b010: return 1;
            3'b001: return -1;
            default: return 99;
        endcase
    endfunction

    function automatic int ref_order(input logic [15:0] a, input logic [15:0] b,
                                     input int w, input logic sm);
        longint av, bv;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        if (av > bv) return 1;
        if (av < bv) return -1;
        return 0;
    endfunction

    function automatic int ref_groups(input logic [15:0] a, input logic [15:0] b,
                                      input int w, input int d);
        int x;
        int n;
        x = int'(a ^ b);
        n = w / d;
        for (int g = n - 1; g >= 0; g--) begin
            if (((x >> (g * d)) & ((1 << d) - 1)) != 0) return n - g;
        end
        return n;
    endfunction

    // Start one compare and follow it to the done cycle. start is raised in
    // cycle 'poke' (ignored while busy) and kept high throughout if 'hold'.
    // Returns with the caller positioned in the done cycle.
    task automatic run(input int which, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input int poke, input bit hold,
                       output int m, output int ord, output bit timed_out);
        logic [4:0] o;
        int nd;
        nd = width_of(which) / digit_of(which);
        set_in(which, a, b, sm, 1'b1);
        tick();
        set_start(which, hold);
        o = outs(which);
        tests++;
        if (o !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL accept dut%0d: got %b, expected 10000", which, o);
        end
        m = 0;
        ord = 99;
        timed_out = 1'b1;
        for (int c = 1; c <= nd + 2; c++) begin
            o = outs(which);
            if (o[3]) begin
                timed_out = 1'b0;
                ord = decode(o);
                break;
            end
            if (o[4]) m++;
            set_start(which, hold || (c == poke));
            tick();
        end
        if (!hold) set_start(which, 1'b0);
    endtask

    task automatic check_result(input string name, input int which,
                                input logic [15:0] a, input logic [15:0] b, input logic sm,
                                input int m, input int ord, input bit timed_out);
        int exp_ord;
        int exp_m;
        exp_ord = ref_order(a, b, width_of(which), sm);
        exp_m = ref_groups(a, b, width_of(which), digit_of(which));
        tests++;
        if (timed_out || ord != exp_ord || m != exp_m) begin
            fails++;
            $display("[TB] FAIL %s dut%0d a=%h b=%h sm=%0d: got ord=%0d m=%0d timeout=%0d, expected ord=%0d m=%0d",
                     name, which, a, b, sm, ord, m, timed_out, exp_ord, exp_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tests++;
        if ({outs(0), outs(1), outs(2)} !== 15'b0) begin
            fails++;
            $display("[TB] FAIL reset: got %b %b %b, expected all 0", outs(0), outs(1), outs(2));
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({outs(0), outs(1), outs(2)} !== 15'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle: got %b %b %b, expected all 0", outs(0), outs(1), outs(2));
        end
    endtask

    task automatic test_equal_hold();
        int m, ord;
        bit to;
        run(0, 16'h1234, 16'h1234, 1'b0, 0, 1'b0, m, ord, to);
        check_result("equal", 0, 16'h1234, 16'h1234, 1'b0, m, ord, to);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (outs(0) !== 5'b00100) begin
                fails++;
                $display("[TB] FAIL eq_hold: got %b, expected 00100", outs(0));
            end
        end
    endtask

    task automatic test_sign_mode();
        int m, ord;
        bit to;
        run(0, 16'h9000, 16'h1FFF, 1'b0, 0, 1'b0, m, ord, to);
        check_result("unsigned_msb", 0, 16'h9000, 16'h1FFF, 1'b0, m, ord, to);
        tick();
        run(0, 16'h9000, 16'h1FFF, 1'b1, 0, 1'b0, m, ord, to);
        check_result("signed_msb", 0, 16'h9000, 16'h1FFF, 1'b1, m, ord, to);
        tick();
        run(0, 16'h0000, 16'hFFFF, 1'b0, 0, 1'b0, m, ord, to);
        check_result("zeros_ones_u", 0, 16'h0000, 16'hFFFF, 1'b0, m, ord, to);
        tick();
        run(0, 16'h0000, 16'hFFFF, 1'b1, 0, 1'b0, m, ord, to);
        check_result("zeros_ones_s", 0, 16'h0000, 16'hFFFF, 1'b1, m, ord, to);
        tick();
    endtask

    task automatic test_start_while_busy();
        int m, ord;
        bit to;
        int extra_done;
        run(0, 16'h00A5, 16'h00A6, 1'b0, 2, 1'b0, m, ord, to);
        check_result("busy_poke", 0, 16'h00A5, 16'h00A6, 1'b0, m, ord, to);
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (outs(0) !== 5'b00001) extra_done++;
        end
        tests++;
        if (extra_done != 0) begin
            fails++;
            $display("[TB] FAIL busy_poke_after: got %0d bad cycles, expected 0 (last %b)", extra_done, outs(0));
        end
    endtask

    task automatic test_back_to_back();
        int m, ord;
        bit to;
        run(0, 16'h0001, 16'h0000, 1'b0, 0, 1'b1, m, ord, to);
        check_result("b2b_first", 0, 16'h0001, 16'h0000, 1'b0, m, ord, to);
        // run() raises start in this DONE cycle; its accept check sees flags cleared.
        run(0, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b1, m, ord, to);
        check_result("b2b_second", 0, 16'hFFFF, 16'hFFFF, 1'b0, m, ord, to);
        set_start(0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int m, ord;
        bit to;
        int bad;
        set_in(0, 16'h00A5, 16'h00A6, 1'b0, 1'b1);
        tick();
        set_start(0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (outs(0) !== 5'b00000) begin
            fails++;
            $display("[TB] FAIL reset_mid_scan: got %b, expected 00000", outs(0));
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (outs(0) !== 5'b00000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL reset_no_done: got %0d active cycles, expected 0", bad);
        end
        run(0, 16'h7F00, 16'h7E11, 1'b1, 0, 1'b0, m, ord, to);
        check_result("after_reset", 0, 16'h7F00, 16'h7E11, 1'b1, m, ord, to);
        tick();
    endtask

    task automatic test_random16();
        int m, ord;
        bit to;
        logic [15:0] a, b;
        logic sm;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 2))
                0: b = 16'($urandom);
                1: b = a;
                default: b = a ^ (16'd1 << $urandom_range(0, 15));
            endcase
            sm = 1'($urandom_range(0, 1));
            run(0, a, b, sm, 0, 1'b0, m, ord, to);
            check_result("random16", 0, a, b, sm, m, ord, to);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_exhaustive4();
        int m, ord;
        bit to;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run(1, 16'(x), 16'(y), 1'(s), 0, 1'b0, m, ord, to);
                    check_result("exhaustive4", 1, 16'(x), 16'(y), 1'(s), m, ord, to);
                end
            end
        end
        tick();
    endtask

    task automatic test_single_group();
        int m, ord;
        bit to;
        logic [15:0] a, b;
        logic sm;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom_range(0, 255));
            b = (i % 4 == 0) ? a : 16'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            run(2, a, b, sm, 0, 1'b0, m, ord, to);
            check_result("single_group", 2, a, b, sm, m, ord, to);
        end
        tick();
    endtask

    initial begin
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0);
        set_in(1, 16'h0, 16'h0, 1'b0, 1'b0);
        set_in(2, 16'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_equal_hold();
        test_sign_mode();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_scan();
        test_random16();
        test_exhaustive4();
        test_single_group();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands in unsigned or two's-complement mode. It scans DIGIT bits per cycle, most-significant group first, and stops at the first unequal group. A start/busy/done handshake lets wide operands share one narrow compare datapath. It is the generalised successor to the lab's fixed 4-bit combinational EQ/GT/LT comparator.

## Interface
- WIDTH, 16: operand width; must be a positive multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- signed_mode  input  1  1 = two's-complement compare; sampled with a/b.
- busy  output  1  high while scanning (CMP state).
- done  output  1  one-cycle pulse; result valid.
- eq, gt, lt  output  1 each  result flags; A relative to B.

## Operation
- NDIG = WIDTH/DIGIT. Groups are indexed NDIG-1 (MSBs) down to 0.
- States:
  - IDLE: busy=0, done=0. start=1 latches a, b and signed_mode, clears eq/gt/lt, sets idx=NDIG-1, and goes to CMP.
  - CMP: busy=1. Each edge compares group idx of the latched operands.
    - Group unequal: set gt or lt from that group, go to DONE.
    - Group equal and idx==0: set eq=1, go to DONE.
    - Otherwise: idx decrements and the state stays CMP.
  - DONE: done=1, busy=0. start=1 is accepted exactly as in IDLE (back-to-back operation); otherwise the state returns to IDLE.
- Signed mode: the sign bit (bit WIDTH-1) of both latched operands is inverted before comparing. The unsigned scan then yields the signed order.
- Flags: exactly one of eq/gt/lt is high from the DONE cycle until the next accepted start. All three are 0 before the first result and immediately after an accepted start.
- start while busy=1 is ignored; the latched operands are never disturbed.
- Inputs a, b and signed_mode may change freely after the accepting edge.

## Timing
- Reset: state=IDLE and idx=0. busy, done, eq, gt and lt are all 0 on the cycle after the reset edge.
- rst has priority over start and over every state transition.
- A reset mid-scan aborts with no done pulse.
- Latency: m = number of groups examined (1..NDIG). Let start be accepted at edge 0.
  - busy is high for cycles 1..m.
  - done and the flags are valid in the cycle after edge m.
  - Best case is 2 cycles from start to the done cycle; worst case is NDIG+1.
- Throughput: with start held high continuously, one result is produced every m+1 cycles.
- Boundaries:
  - DIGIT=WIDTH: always m=1.
  - Operands all-zeros vs all-ones: decided in group NDIG-1.
  - idx never wraps below 0.

## Structure
- Shared package cmp_pkg holds:
  - the state encoding (IDLE, CMP, DONE);
  - a helper or constant for NDIG;
  - an elaboration-time check that WIDTH % DIGIT == 0.
- One sub-module, digit_cmp: a combinational DIGIT-bit compare producing grp_eq and grp_gt, with grp_lt = ~grp_eq & ~grp_gt. It is instanced once and fed by an idx-selected slice.
- The top level holds the FSM, idx counter, operand registers and result flags.

## Test plan
- WIDTH=16, DIGIT=4, unsigned, a=16'h1234, b=16'h1234, start pulse → busy for 4 cycles, done in cycle 5, eq=1, gt=lt=0; flags hold until the next start.
- Unsigned, a=16'h9000, b=16'h1FFF → done in cycle 2, gt=1. The same operands with signed_mode=1 → done in cycle 2, lt=1.
- Unsigned, a=16'h00A5, b=16'h00A6 → busy for 4 cycles, lt=1. A start pulse during cycle 2 is ignored: one done only, result unchanged.
- start held high with pairs (16'h0001, 16'h0000) then (16'hFFFF, 16'hFFFF) → the second pair is accepted on the DONE cycle of the first. Results are gt then eq; flags read 0 between the two accepts.
- rst asserted in cycle 2 of a 4-group scan → busy, done and flags are 0 the next cycle with no done pulse. A fresh start afterwards completes normally.
- WIDTH=4, DIGIT=1: exhaustive over all 256 (a,b) pairs in both modes against the behavioural <, ==, >. m always equals the index of the first differing bit from the MSB, plus 1.
